// File: rtl/bg_sdram_arbiter.sv
// Merges the BG layers' Avalon-MM read ports onto one SDRAM master and routes each return to the layer that issued it.
// Define BG_ARB_FIXED_PRIO_EN for fixed lowest-index priority; the default is round-robin.
module bg_sdram_arbiter #(
    parameter int unsigned pPORTS       = 4,
    parameter int unsigned pADDR_W      = 23,
    parameter int unsigned pMAX_PENDING = 8
) (
    input  logic                        iCLOCK,
    input  logic                        iRESET_N,
    input  logic [pPORTS*pADDR_W-1:0]   iREQ_ADDRESS,
    input  logic [pPORTS-1:0]           iREQ_READ,
    output logic [pPORTS-1:0]           oREQ_WAIT_REQUEST,
    output logic [15:0]                 oREQ_READ_DATA,
    output logic [pPORTS-1:0]           oREQ_READ_DATA_VALID,
    output logic [pADDR_W-1:0]          oSDRAM_ADDRESS,
    output logic                        oSDRAM_READ,
    input  logic                        iSDRAM_WAIT_REQUEST,
    input  logic [15:0]                 iSDRAM_READ_DATA,
    input  logic                        iSDRAM_READ_DATA_VALID,
    output logic                        oERROR
);

    localparam int unsigned GRANT_W = (pPORTS > 1) ? $clog2(pPORTS) : 1;
    localparam int unsigned PTR_W   = (pMAX_PENDING > 1) ? $clog2(pMAX_PENDING) : 1;
    localparam int unsigned CNT_W   = $clog2(pMAX_PENDING + 1);
    localparam int unsigned DATA_W  = 16;

    typedef enum logic {
        sIDLE  = 1'b0,
        sISSUE = 1'b1
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [GRANT_W-1:0]     r_grant, w_grant_nxt;
    logic [pADDR_W-1:0]     r_addr, w_addr_nxt;
    logic                   r_read, w_read_nxt;
    logic [DATA_W-1:0]      r_rd_data;
    logic [pPORTS-1:0]      r_rd_valid;
    logic                   r_error;

    logic [GRANT_W-1:0]     r_fifo [pMAX_PENDING];
    logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic                   w_full, w_empty, w_push, w_pop;
    logic [GRANT_W-1:0]     w_head;
    logic                   w_found;
    logic [GRANT_W-1:0]     w_winner;
    logic [pADDR_W-1:0]     w_port_addr [pPORTS];

`ifndef BG_ARB_FIXED_PRIO_EN
    logic [GRANT_W-1:0]     r_last, w_last_nxt;
    logic                   w_hi_found, w_lo_found;
    logic [GRANT_W-1:0]     w_hi_idx, w_lo_idx;
`endif

    for (genvar g = 0; g < int'(pPORTS); g++) begin : g_addr
        assign w_port_addr[g] = iREQ_ADDRESS[g*pADDR_W +: pADDR_W];
    end

    assign w_full  = (r_count == CNT_W'(pMAX_PENDING));
    assign w_empty = (r_count == '0);
    assign w_push  = (r_state == sISSUE) && !iSDRAM_WAIT_REQUEST;
    assign w_pop   = iSDRAM_READ_DATA_VALID && !w_empty;
    assign w_head  = r_fifo[r_rd_ptr];

`ifdef BG_ARB_FIXED_PRIO_EN
    // Lowest requesting index wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = int'(pPORTS) - 1; i >= 0; i--) begin
            if (iREQ_READ[i]) begin
                w_found  = 1'b1;
                w_winner = GRANT_W'(i);
            end
        end
    end
`else
    // First requester above r_last wins; otherwise wrap to the lowest requester.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = int'(pPORTS) - 1; i >= 0; i--) begin
            if (iREQ_READ[i]) begin
                if (GRANT_W'(i) > r_last) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = GRANT_W'(i);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = GRANT_W'(i);
                end
            end
        end
        w_found  = w_hi_found || w_lo_found;
        w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end
`endif

    // Next-state and issue-register logic.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_addr_nxt  = r_addr;
        w_read_nxt  = r_read;
`ifndef BG_ARB_FIXED_PRIO_EN
        w_last_nxt  = r_last;
`endif
        case (r_state)
            sIDLE: begin
                if (w_found && !w_full) begin
                    w_state_nxt = sISSUE;
                    w_grant_nxt = w_winner;
                    w_addr_nxt  = w_port_addr[w_winner];
                    w_read_nxt  = 1'b1;
`ifndef BG_ARB_FIXED_PRIO_EN
                    w_last_nxt  = w_winner;
`endif
                end
            end
            sISSUE: begin
                if (!iSDRAM_WAIT_REQUEST) begin
                    w_state_nxt = sIDLE;
                    w_read_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = sIDLE;
                w_read_nxt  = 1'b0;
            end
        endcase
    end

    // Only the granted port sees waitrequest low, and only in its acceptance cycle.
    always_comb begin
        oREQ_WAIT_REQUEST = '1;
        if (w_push) begin
            oREQ_WAIT_REQUEST[r_grant] = 1'b0;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (!iRESET_N) begin
            r_state    <= sIDLE;
            r_grant    <= '0;
            r_addr     <= '0;
            r_read     <= 1'b0;
`ifndef BG_ARB_FIXED_PRIO_EN
            r_last     <= GRANT_W'(pPORTS - 1);
`endif
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_addr     <= w_addr_nxt;
            r_read     <= w_read_nxt;
`ifndef BG_ARB_FIXED_PRIO_EN
            r_last     <= w_last_nxt;
`endif
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_rd_valid <= '0;
            if (w_pop) begin
                r_rd_valid <= pPORTS'(1) << w_head;
                r_rd_data  <= iSDRAM_READ_DATA;
            end
            if (iSDRAM_READ_DATA_VALID && w_empty) begin
                r_error <= 1'b1;
            end
        end
    end

    // Owner storage needs no reset; the pointers and count define validity.
    always_ff @(posedge iCLOCK) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= r_grant;
        end
    end

    assign oSDRAM_ADDRESS       = r_addr;
    assign oSDRAM_READ          = r_read;
    assign oREQ_READ_DATA       = r_rd_data;
    assign oREQ_READ_DATA_VALID = r_rd_valid;
    assign oERROR               = r_error;

endmodule

// File: tb/tb_bg_sdram_arbiter.sv
// Directed self-checking bench for bg_sdram_arbiter (4 ports, 23-bit address, 8 pending).
module tb_bg_sdram_arbiter;

    logic         clk;
    logic         rst_n;
    logic [91:0]  req_addr;
    logic [3:0]   req_read;
    logic [3:0]   wait_req_o;
    logic [15:0]  rd_data;
    logic [3:0]   rd_valid;
    logic [22:0]  sd_addr;
    logic         sd_read;
    logic         sd_wait;
    logic [15:0]  sd_data;
    logic         sd_valid;
    logic         err;

    int total;
    int bad;

    bg_sdram_arbiter #(
        .pPORTS       (4),
        .pADDR_W      (23),
        .pMAX_PENDING (8)
    ) dut (
        .iCLOCK                 (clk),
        .iRESET_N               (rst_n),
        .iREQ_ADDRESS           (req_addr),
        .iREQ_READ              (req_read),
        .oREQ_WAIT_REQUEST      (wait_req_o),
        .oREQ_READ_DATA         (rd_data),
        .oREQ_READ_DATA_VALID   (rd_valid),
        .oSDRAM_ADDRESS         (sd_addr),
        .oSDRAM_READ            (sd_read),
        .iSDRAM_WAIT_REQUEST    (sd_wait),
        .iSDRAM_READ_DATA       (sd_data),
        .iSDRAM_READ_DATA_VALID (sd_valid),
        .oERROR                 (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int p, input logic [22:0] a);
        req_addr[p*23 +: 23] = a;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req_read = '0;
        sd_valid = 1'b0;
        sd_wait  = 1'b0;
        sd_data  = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Raise one port's read and hold it until acceptance (controller wait=0).
    task automatic issue_one(input int p);
        logic acc;
        acc = 1'b0;
        req_read = 4'b0001 << p;
        for (int c = 0; c < 10 && !acc; c++) begin
            tick();
            if (sd_read && !wait_req_o[p]) acc = 1'b1;
        end
        tick();
        req_read = '0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL issue_one: port %0d got accepted=%0b want 1", p, acc);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        req_addr = '0;
        req_read = '0;
        sd_wait  = 1'b0;
        sd_data  = '0;
        sd_valid = 1'b0;
        tick();
        tick();
        total++; if (sd_read !== 1'b0) begin bad++; $display("FAIL reset_read: got %0b want 0", sd_read); end
        total++; if (sd_addr !== 23'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", sd_addr); end
        total++; if (wait_req_o !== 4'hF) begin bad++; $display("FAIL reset_wait: got %b want 1111", wait_req_o); end
        total++; if (rd_data !== 16'h0) begin bad++; $display("FAIL reset_data: got %h want 0", rd_data); end
        total++; if (rd_valid !== 4'h0) begin bad++; $display("FAIL reset_valid: got %b want 0000", rd_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", err); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0] exp_w;
        do_reset();
        set_addr(2, 23'h000123);
        req_read = 4'b0100;
        sd_wait  = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            sd_wait = (c < 3);
            #1;
            exp_w = (c < 3) ? 4'hF : 4'b1011;
            total++; if (sd_read !== 1'b1) begin bad++; $display("FAIL single_read c%0d: got %0b want 1", c, sd_read); end
            total++; if (sd_addr !== 23'h000123) begin bad++; $display("FAIL single_addr c%0d: got %h want 000123", c, sd_addr); end
            total++; if (wait_req_o !== exp_w) begin bad++; $display("FAIL single_wait c%0d: got %b want %b", c, wait_req_o, exp_w); end
            tick();
        end
        req_read = '0;
        sd_wait  = 1'b1;
        #1;
        total++; if (sd_read !== 1'b0) begin bad++; $display("FAIL single_read_done: got %0b want 0", sd_read); end
        total++; if (wait_req_o !== 4'hF) begin bad++; $display("FAIL single_wait_done: got %b want 1111", wait_req_o); end
        tick(); tick(); tick(); tick();
        sd_valid = 1'b1;
        sd_data  = 16'hBEEF;
        #1;
        total++; if (rd_valid !== 4'h0) begin bad++; $display("FAIL single_early_valid: got %b want 0000", rd_valid); end
        tick();
        sd_valid = 1'b0;
        total++; if (rd_valid !== 4'b0100) begin bad++; $display("FAIL single_ret_valid: got %b want 0100", rd_valid); end
        total++; if (rd_data !== 16'hBEEF) begin bad++; $display("FAIL single_ret_data: got %h want beef", rd_data); end
        tick();
        total++; if (rd_valid !== 4'h0) begin bad++; $display("FAIL single_valid_pulse: got %b want 0000", rd_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err: got %0b want 0", err); end
    endtask

    task automatic test_round_robin();
        int n;
        int exp_p;
        logic [3:0] exp_w;
        logic [22:0] exp_a;
        do_reset();
        for (int i = 0; i < 4; i++) set_addr(i, 23'h000100 + 23'(i));
        req_read = 4'hF;
        sd_wait  = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 5; cyc++) begin
            tick();
            if (sd_read) begin
`ifdef BG_ARB_FIXED_PRIO_EN
                exp_p = 0;
`else
                exp_p = n % 4;
`endif
                exp_w = ~(4'b0001 << exp_p);
                exp_a = 23'h000100 + 23'(exp_p);
                total++; if (wait_req_o !== exp_w) begin bad++; $display("FAIL rr_grant %0d: got %b want %b", n, wait_req_o, exp_w); end
                total++; if (sd_addr !== exp_a) begin bad++; $display("FAIL rr_addr %0d: got %h want %h", n, sd_addr, exp_a); end
                n++;
            end
        end
        req_read = '0;
        total++; if (n !== 5) begin bad++; $display("FAIL rr_count: got %0d want 5", n); end
    endtask

    task automatic test_routing();
        logic [15:0] d [3];
        logic [3:0]  e [3];
        d[0] = 16'hA001; d[1] = 16'hA003; d[2] = 16'hA000;
        e[0] = 4'b0010;  e[1] = 4'b1000;  e[2] = 4'b0001;
        do_reset();
        issue_one(1);
        issue_one(3);
        issue_one(0);
        for (int k = 0; k < 3; k++) begin
            sd_valid = 1'b1;
            sd_data  = d[k];
            tick();
            total++; if (rd_valid !== e[k]) begin bad++; $display("FAIL route_valid %0d: got %b want %b", k, rd_valid, e[k]); end
            total++; if (rd_data !== d[k]) begin bad++; $display("FAIL route_data %0d: got %h want %h", k, rd_data, d[k]); end
        end
        sd_valid = 1'b0;
        tick();
        total++; if (rd_valid !== 4'h0) begin bad++; $display("FAIL route_idle: got %b want 0000", rd_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL route_err: got %0b want 0", err); end
    endtask

    task automatic test_fifo_full();
        int acc;
        do_reset();
        req_read = 4'hF;
        sd_wait  = 1'b0;
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (sd_read && wait_req_o !== 4'hF) acc++;
        end
        total++; if (acc !== 8) begin bad++; $display("FAIL full_accepts: got %0d want 8", acc); end
        total++; if (sd_read !== 1'b0) begin bad++; $display("FAIL full_read_low: got %0b want 0", sd_read); end
        sd_valid = 1'b1;
        sd_data  = 16'h5A5A;
        tick();
        sd_valid = 1'b0;
        total++; if (rd_valid !== 4'b0001) begin bad++; $display("FAIL full_ret_valid: got %b want 0001", rd_valid); end
        total++; if (rd_data !== 16'h5A5A) begin bad++; $display("FAIL full_ret_data: got %h want 5a5a", rd_data); end
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (sd_read && wait_req_o !== 4'hF) acc++;
        end
        total++; if (acc !== 1) begin bad++; $display("FAIL full_refill: got %0d want 1", acc); end
        req_read = '0;
    endtask

    task automatic test_stray();
        do_reset();
        sd_valid = 1'b1;
        sd_data  = 16'hDEAD;
        tick();
        sd_valid = 1'b0;
        total++; if (rd_valid !== 4'h0) begin bad++; $display("FAIL stray_valid: got %b want 0000", rd_valid); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL stray_err: got %0b want 1", err); end
        tick(); tick(); tick();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL stray_sticky: got %0b want 1", err); end
        rst_n = 1'b0;
        tick();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL stray_clear: got %0b want 0", err); end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_issue();
        do_reset();
        for (int i = 0; i < 4; i++) set_addr(i, 23'h004000 + 23'(i));
        req_read = 4'b0100;
        sd_wait  = 1'b1;
        tick();
        total++; if (sd_read !== 1'b1) begin bad++; $display("FAIL rsti_issue: got %0b want 1", sd_read); end
        rst_n   = 1'b0;
        sd_wait = 1'b0;
        tick();
        total++; if (sd_read !== 1'b0) begin bad++; $display("FAIL rsti_read: got %0b want 0", sd_read); end
        total++; if (wait_req_o !== 4'hF) begin bad++; $display("FAIL rsti_wait: got %b want 1111", wait_req_o); end
        rst_n    = 1'b1;
        req_read = 4'hF;
        tick();
        total++; if (wait_req_o !== 4'b1110) begin bad++; $display("FAIL rsti_first: got %b want 1110", wait_req_o); end
        total++; if (sd_addr !== 23'h004000) begin bad++; $display("FAIL rsti_addr: got %h want 004000", sd_addr); end
        req_read = '0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_routing();
        test_fifo_full();
        test_stray();
        test_reset_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bg_sdram_arbiter.md
# bg_sdram_arbiter

Read-side responder for the BG renderers' SDRAM master ports. It presents one Avalon-MM read-only slave port per BG layer and merges them onto the single SDRAM controller master port. It uses round-robin grant, holds the address stable while waitrequest is asserted, and routes each pipelined `readdatavalid` return back to the layer that issued it. It sits in VID_MIXER between the BG instances and the SDRAM controller.

## Interface
- `pPORTS`, 4 — number of BG slave ports (2..8).
- `pADDR_W`, 23 — SDRAM word-address width (tADDR width).
- `pMAX_PENDING`, 8 — owner-FIFO depth, i.e. maximum outstanding reads accepted by the SDRAM controller (power of 2).

Ports:
- `iCLOCK`  in  1  — system clock.
- `iRESET_N`  in  1  — synchronous, active-low reset.
- `iREQ_ADDRESS`  in  pPORTS×pADDR_W  — per-port read address.
- `iREQ_READ`  in  pPORTS  — per-port read request.
- `oREQ_WAIT_REQUEST`  out  pPORTS  — per-port waitrequest.
- `oREQ_READ_DATA`  out  16  — return data, broadcast to all ports.
- `oREQ_READ_DATA_VALID`  out  pPORTS  — per-port one-hot return strobe.
- `oSDRAM_ADDRESS`  out  pADDR_W  — to SDRAM controller.
- `oSDRAM_READ`  out  1  — to SDRAM controller.
- `iSDRAM_WAIT_REQUEST`  in  1  — from SDRAM controller.
- `iSDRAM_READ_DATA`  in  16  — from SDRAM controller.
- `iSDRAM_READ_DATA_VALID`  in  1  — from SDRAM controller.
- `oERROR`  out  1  — sticky; a return arrived while the owner FIFO was empty.

## Operation
- The state machine has two states, sIDLE and sISSUE.
- In sIDLE, the block arbitrates when any `iREQ_READ` is set and the owner FIFO is not full.
  - The winner is the first requesting port after `rLAST` (modulo pPORTS).
  - The block latches the winner's address into `oSDRAM_ADDRESS` and the winner index into `rGRANT`, sets `rLAST`=winner, and moves to sISSUE.
  - With no request, or with the FIFO full, the block stays in sIDLE.
- In sISSUE, `oSDRAM_READ`=1 and the address is held.
  - On the first cycle with `iSDRAM_WAIT_REQUEST`=0, the read is accepted: push `rGRANT` into the FIFO, clear `oSDRAM_READ` at the next edge, and go to sIDLE.
- `oREQ_WAIT_REQUEST[i]` is combinational: it is 0 only when state is sISSUE, `rGRANT`=i and `iSDRAM_WAIT_REQUEST`=0. It is 1 in every other case, including sIDLE.
- Each port receives exactly one waitrequest-low cycle per accepted read.
- Return path: on `iSDRAM_READ_DATA_VALID`=1 with the FIFO non-empty:
  - Pop the head owner h.
  - On the next edge, register `oREQ_READ_DATA`=`iSDRAM_READ_DATA` and `oREQ_READ_DATA_VALID`=one-hot(h) for one cycle.
- Returns are in order. The SDRAM controller guarantees in-order returns, so FIFO order equals issue order.
- FIFO full is judged on the registered count. A grant is blocked when count==pMAX_PENDING, even if a pop occurs in the same cycle.
- A push and a pop in the same cycle leave the count unchanged.
- A return while the FIFO is empty is dropped: no valid strobe is driven and `oERROR` is set. `oERROR` is cleared only by reset.
- A port that drops `iREQ_READ` while it is granted in sISSUE does not cancel the issue. Avalon masters must hold read; the arbiter completes the read and delivers the return.

## Timing
- Reset values:
  - state sIDLE, `rLAST`=pPORTS-1 (port 0 wins first), FIFO empty.
  - `oSDRAM_READ`=0, `oSDRAM_ADDRESS`=0.
  - `oREQ_WAIT_REQUEST`=all 1s.
  - `oREQ_READ_DATA`=0, `oREQ_READ_DATA_VALID`=0, `oERROR`=0.
- Issue latency:
  - Request seen in sIDLE at cycle N: `oSDRAM_READ`=1 from N+1.
  - Acceptance at the first cycle M≥N+1 with wait=0, with the port's waitrequest low in cycle M.
  - Back in sIDLE at M+1; next grant no earlier than M+1, so next issue no earlier than M+2.
  - Peak throughput: 1 read per 2 cycles.
- Return latency: exactly 1 cycle from `iSDRAM_READ_DATA_VALID` to `oREQ_READ_DATA_VALID`.
- Reset mid-operation:
  - The FIFO and state are cleared immediately.
  - Returns still in flight after reset are dropped and set `oERROR`.
  - The SDRAM controller must be reset together with this block.

## Configuration
- `BG_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest port index wins; `rLAST` is unused and removed.
  - Undefined (default): round-robin as described above.
- All other behaviour is identical in both cases.

## Test plan
- Single read, controller with wait=1 for 3 cycles:
  - Stimulus: port 2 reads 0x000123.
  - Required: `oSDRAM_ADDRESS`=0x000123 with read held 4 cycles; `oREQ_WAIT_REQUEST[2]` low only in the acceptance cycle.
  - Required: controller returns 0xBEEF 5 cycles later, and `oREQ_READ_DATA_VALID`=0b0100 with data 0xBEEF one cycle after that.
- All 4 ports requesting continuously, wait=0:
  - Required grant order 0,1,2,3,0.
  - With `BG_ARB_FIXED_PRIO_EN`, port 0 is granted every time.
- Return owner routing:
  - Stimulus: controller delays returns until 3 reads from ports 1, 3, 0 are accepted.
  - Required: valids in order 0b0010, 0b1000, 0b0001 with matching data.
- FIFO full:
  - Stimulus: controller withholds returns, requests continuous.
  - Required: exactly 8 acceptances, then `oSDRAM_READ` stays 0.
  - Required: one return, then exactly one new issue.
- Stray return:
  - Stimulus: `iSDRAM_READ_DATA_VALID` with the FIFO empty.
  - Required: no `oREQ_READ_DATA_VALID`; `oERROR`=1 and stays 1 until `iRESET_N`=0.
- Reset while in sISSUE:
  - Required: the next cycle shows `oSDRAM_READ`=0 and all waitrequests 1.
  - Required: after release, port 0 wins first.
